// File: rtl/bus_arbiter2_if.sv
// Shared signal bundle between the two requesting masters and the arbiter.
// The arbiter connects through the slave modport; the masters side (or a
// testbench standing in for them) uses the master modport.
interface bus_arbiter2_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 32
);
   logic              m0_req;
   logic              m0_wr;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_dout;
   logic              m1_req;
   logic              m1_wr;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_dout;
   logic              m0_grant;
   logic              m1_grant;
   logic              bus_req;
   logic              bus_wr;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_dout;

   modport master (
      output m0_req, m0_wr, m0_addr, m0_dout,
      output m1_req, m1_wr, m1_addr, m1_dout,
      input  m0_grant, m1_grant, bus_req, bus_wr, bus_addr, bus_dout
   );

   modport slave (
      input  m0_req, m0_wr, m0_addr, m0_dout,
      input  m1_req, m1_wr, m1_addr, m1_dout,
      output m0_grant, m1_grant, bus_req, bus_wr, bus_addr, bus_dout
   );
endinterface

// File: rtl/bus_arbiter2.sv
// Two-master round-robin arbiter with a hold limit in front of the shared bus.
// Grants decode straight from the state register; the bus mux is
// combinational from that state, so IDLE (and reset) forces all-zero outputs.
module bus_arbiter2 #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   bus_arbiter2_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     state_q, state_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       last_owner_q, last_owner_d;

   // State, hold counter and last-owner registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         hold_cnt_q   <= '0;
         last_owner_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         last_owner_q <= last_owner_d;
      end
   end

   // Next-state arbitration, hold counter and last-owner tracking.
   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      last_owner_d = last_owner_q;

      unique case (state_q)
         IDLE: begin
            if (bus.m0_req && !bus.m1_req)      state_d = G0;
            else if (bus.m1_req && !bus.m0_req) state_d = G1;
            else if (bus.m0_req && bus.m1_req)  state_d = last_owner_q ? G0 : G1;
            else                                state_d = IDLE;
         end
         G0: begin
            if (!bus.m0_req && bus.m1_req)       state_d = G1;
            else if (!bus.m0_req && !bus.m1_req) state_d = IDLE;
            else if (bus.m1_req && hold_cnt_q == HOLD_LAST) state_d = G1;
            else                                 state_d = G0;
         end
         G1: begin
            if (!bus.m1_req && bus.m0_req)       state_d = G0;
            else if (!bus.m1_req && !bus.m0_req) state_d = IDLE;
            else if (bus.m0_req && hold_cnt_q == HOLD_LAST) state_d = G0;
            else                                 state_d = G1;
         end
         default: state_d = IDLE;
      endcase

      // Counter runs only while an owner keeps the bus; it pins at the last
      // value when uncontested, so a late request triggers handover at once.
      if (state_d != state_q || state_d == IDLE) begin
         hold_cnt_d = '0;
      end else if (hold_cnt_q != HOLD_LAST) begin
         hold_cnt_d = hold_cnt_q + 8'd1;
      end

      if (state_d == G0) last_owner_d = 1'b0;
      if (state_d == G1) last_owner_d = 1'b1;
   end

   // Grant decode and bus mux; IDLE drives zeros so no spurious write occurs.
   always_comb begin
      bus.m0_grant = (state_q == G0);
      bus.m1_grant = (state_q == G1);
      bus.bus_req  = (state_q == G0) || (state_q == G1);
      bus.bus_wr   = 1'b0;
      bus.bus_addr = '0;
      bus.bus_dout = '0;
      if (state_q == G0) begin
         bus.bus_wr   = bus.m0_wr;
         bus.bus_addr = bus.m0_addr;
         bus.bus_dout = bus.m0_dout;
      end else if (state_q == G1) begin
         bus.bus_wr   = bus.m1_wr;
         bus.bus_addr = bus.m1_addr;
         bus.bus_dout = bus.m1_dout;
      end
   end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2: each step drives inputs, pushes the
// expected post-edge outputs onto a scoreboard queue, then pops and compares
// after the clock edge.
module tb_bus_arbiter2;

   localparam int unsigned ADDR_W   = 16;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned MAX_HOLD = 8;

   logic clk;
   logic reset_n;

   bus_arbiter2_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

   bus_arbiter2 #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic              m0g;
      logic              m1g;
      logic              req;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] dout;
      logic [7:0]        hold;
   } exp_t;

   exp_t exp_q[$];

   int tests;
   int fails;

   // Reference model state: 0 = IDLE, 1 = G0, 2 = G1
   int         mst;
   logic       mlast;
   logic [7:0] mhold;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mst   = 0;
      mlast = 1'b1;
      mhold = 8'd0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #12;
      reset_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   // Predict the state after the coming edge, push expectation, clock, compare.
   task automatic step(input string tag);
      int   n;
      exp_t e;
      logic r0, r1;
      r0 = bif.m0_req;
      r1 = bif.m1_req;
      n  = mst;
      case (mst)
         0: begin
            if (r0 && !r1)      n = 1;
            else if (r1 && !r0) n = 2;
            else if (r0 && r1)  n = mlast ? 1 : 2;
         end
         1: begin
            if (!r0)            n = r1 ? 2 : 0;
            else if (r1 && mhold == 8'(MAX_HOLD - 1)) n = 2;
         end
         default: begin
            if (!r1)            n = r0 ? 1 : 0;
            else if (r0 && mhold == 8'(MAX_HOLD - 1)) n = 1;
         end
      endcase
      if (n != mst || n == 0)            mhold = 8'd0;
      else if (mhold < 8'(MAX_HOLD - 1)) mhold = mhold + 8'd1;
      if (n == 1) mlast = 1'b0;
      if (n == 2) mlast = 1'b1;
      mst = n;

      e.m0g  = (n == 1);
      e.m1g  = (n == 2);
      e.req  = (n != 0);
      e.wr   = (n == 1) ? bif.m0_wr   : (n == 2) ? bif.m1_wr   : 1'b0;
      e.addr = (n == 1) ? bif.m0_addr : (n == 2) ? bif.m1_addr : '0;
      e.dout = (n == 1) ? bif.m0_dout : (n == 2) ? bif.m1_dout : '0;
      e.hold = mhold;
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, ".m0_grant"}, 64'(bif.m0_grant), 64'(e.m0g));
      check({tag, ".m1_grant"}, 64'(bif.m1_grant), 64'(e.m1g));
      check({tag, ".bus_req"},  64'(bif.bus_req),  64'(e.req));
      check({tag, ".bus_wr"},   64'(bif.bus_wr),   64'(e.wr));
      check({tag, ".bus_addr"}, 64'(bif.bus_addr), 64'(e.addr));
      check({tag, ".bus_dout"}, 64'(bif.bus_dout), 64'(e.dout));
      check({tag, ".hold_cnt"}, 64'(dut.hold_cnt_q), 64'(e.hold));
      check({tag, ".one_hot"},  64'(bif.m0_grant & bif.m1_grant), 64'(0));
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      reset_n = 1'b1;
      bif.m0_req = 1'b0; bif.m0_wr = 1'b0; bif.m0_addr = '0; bif.m0_dout = '0;
      bif.m1_req = 1'b0; bif.m1_wr = 1'b0; bif.m1_addr = '0; bif.m1_dout = '0;
      model_reset();
      #2;

      // Reset state
      do_reset();
      check("rst.m0_grant", 64'(bif.m0_grant), 64'(0));
      check("rst.m1_grant", 64'(bif.m1_grant), 64'(0));
      check("rst.bus_req",  64'(bif.bus_req),  64'(0));
      check("rst.bus_wr",   64'(bif.bus_wr),   64'(0));
      check("rst.bus_addr", 64'(bif.bus_addr), 64'(0));
      check("rst.bus_dout", 64'(bif.bus_dout), 64'(0));

      // Master 0 alone
      bif.m0_req = 1'b1; bif.m0_wr = 1'b1;
      bif.m0_addr = 16'h0010; bif.m0_dout = 32'hA5A5_0001;
      bif.m1_addr = 16'h0BAD; bif.m1_dout = 32'hDEAD_BEEF; bif.m1_wr = 1'b1;
      step("m0_only");
      check("m0_only.direct_addr", 64'(bif.bus_addr), 64'h0010);
      check("m0_only.direct_dout", 64'(bif.bus_dout), 64'hA5A5_0001);

      // Tie from IDLE goes to master 0, then drop m0 hands to m1
      bif.m0_req = 1'b0;
      step("release");
      do_reset();
      bif.m0_req = 1'b1; bif.m1_req = 1'b1;
      bif.m1_addr = 16'h0200; bif.m1_dout = 32'h1111_2222; bif.m1_wr = 1'b0;
      step("tie");
      check("tie.direct_m0_grant", 64'(bif.m0_grant), 64'(1));
      bif.m0_req = 1'b0;
      step("drop_m0");
      check("drop_m0.direct_m1_grant", 64'(bif.m1_grant), 64'(1));
      check("drop_m0.direct_addr", 64'(bif.bus_addr), 64'h0200);

      // Continuous contention: alternation every MAX_HOLD cycles
      bif.m0_req = 1'b1; bif.m1_req = 1'b1;
      for (int i = 0; i < 40; i++) begin
         bif.m0_addr = 16'($urandom); bif.m1_addr = 16'($urandom);
         bif.m0_wr = 1'($urandom); bif.m1_wr = 1'($urandom);
         step("contend");
      end

      // Master 0 alone for 20 cycles: saturating hold, then late m1 request
      bif.m1_req = 1'b0;
      for (int i = 0; i < 20; i++) step("m0_long");
      check("m0_long.hold_sat", 64'(dut.hold_cnt_q), 64'(MAX_HOLD - 1));
      bif.m1_req = 1'b1;
      step("late_m1");
      check("late_m1.direct_m1_grant", 64'(bif.m1_grant), 64'(1));

      // Idle with toggling addresses: bus must stay zero
      bif.m0_req = 1'b0; bif.m1_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bif.m0_addr = 16'($urandom); bif.m1_addr = 16'($urandom);
         bif.m0_dout = $urandom;      bif.m1_dout = $urandom;
         bif.m0_wr = 1'b1;            bif.m1_wr = 1'b1;
         step("idle");
      end

      // Asynchronous reset while in G1
      bif.m1_req = 1'b1;
      step("to_g1");
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst.m1_grant", 64'(bif.m1_grant), 64'(0));
      check("async_rst.bus_req",  64'(bif.bus_req),  64'(0));
      check("async_rst.bus_wr",   64'(bif.bus_wr),   64'(0));
      #10;
      reset_n = 1'b1;
      model_reset();
      #1;
      step("after_rst");
      check("after_rst.direct_m1_grant", 64'(bif.m1_grant), 64'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
